// File: rtl/rprelu_stream.sv
// rprelu_stream: streaming RPReLU / PReLU / ReLU / bypass activation stage.
// Handles LANES channels per beat and steps through CHANNEL_NUM/LANES channel
// groups. Parameters come from a built-in per-channel table, results are
// saturated, and the two pipeline stages stall together under backpressure.
// Ports:
//   clk, rstn                    clock, synchronous active-low reset
//   in_valid/in_ready            input handshake; in_ready = !out_valid || out_ready
//   in_sof, in_mode, data_in     group-0 marker, activation mode, LANES signed inputs
//   para_we, para_waddr,
//   para_beta/gamma/zeta         parameter table write port (no handshake)
//   out_valid/out_ready          output handshake
//   out_grp, out_last, data_out  group tag, last-group flag, LANES signed results
module rprelu_stream #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned PARA_WIDTH  = 16,
  parameter int unsigned BETA_FRAC   = 8,
  parameter int unsigned CHANNEL_NUM = 128,
  parameter int unsigned LANES       = 16,
  localparam int unsigned GROUPS = CHANNEL_NUM / LANES,
  localparam int unsigned AW     = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1,
  localparam int unsigned GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic                                in_sof,
  input  logic [1:0]                          in_mode,
  input  logic [LANES-1:0][DATA_WIDTH-1:0]    data_in,
  input  logic                                para_we,
  input  logic [AW-1:0]                       para_waddr,
  input  logic [PARA_WIDTH-1:0]               para_beta,
  input  logic [PARA_WIDTH-1:0]               para_gamma,
  input  logic [PARA_WIDTH-1:0]               para_zeta,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [GW-1:0]                       out_grp,
  output logic                                out_last,
  output logic [LANES-1:0][DATA_WIDTH-1:0]    data_out
);

  localparam int unsigned DW1 = DATA_WIDTH + 1;               // width of d = x - g
  localparam int unsigned MW  = DATA_WIDTH + 1 + PARA_WIDTH;  // width of d * beta
  localparam int unsigned SW  = MW + 1;                       // width of y + z before saturation

  localparam logic [1:0] MODE_RPRELU = 2'b00;
  localparam logic [1:0] MODE_PRELU  = 2'b01;
  localparam logic [1:0] MODE_RELU   = 2'b10;

  logic [PARA_WIDTH-1:0] beta_tab  [CHANNEL_NUM];
  logic [PARA_WIDTH-1:0] gamma_tab [CHANNEL_NUM];
  logic [PARA_WIDTH-1:0] zeta_tab  [CHANNEL_NUM];

  logic          adv;
  logic          accept;
  logic [GW-1:0] grp;
  logic [GW-1:0] tag;

  logic [LANES-1:0][AW-1:0]         idx_c;
  logic [LANES-1:0][PARA_WIDTH-1:0] beta_c;
  logic [LANES-1:0][PARA_WIDTH-1:0] gamma_c;
  logic [LANES-1:0][PARA_WIDTH-1:0] zeta_c;
  logic [LANES-1:0][DW1-1:0]        d_c;

  logic                             s1_valid;
  logic [1:0]                       s1_mode;
  logic [GW-1:0]                    s1_grp;
  logic [LANES-1:0][DW1-1:0]        s1_d;
  logic [LANES-1:0][PARA_WIDTH-1:0] s1_beta;
  logic [LANES-1:0][PARA_WIDTH-1:0] s1_zeta;

  logic [LANES-1:0]                 pos_c;
  logic [LANES-1:0][MW-1:0]         prod_c;
  logic [LANES-1:0][SW-1:0]         y_c;
  logic [LANES-1:0][SW-1:0]         sum_c;
  logic [LANES-1:0][DATA_WIDTH-1:0] res_c;

  // Both stages move together; an empty output slot or a taker lets them shift.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign accept   = in_valid && adv;
  assign tag      = in_sof ? '0 : grp;

  // Parameter table; reset has priority over a concurrent write.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int c = 0; c < int'(CHANNEL_NUM); c++) begin
        beta_tab[c]  <= '0;
        gamma_tab[c] <= '0;
        zeta_tab[c]  <= '0;
      end
    end else if (para_we) begin
      beta_tab[para_waddr]  <= para_beta;
      gamma_tab[para_waddr] <= para_gamma;
      zeta_tab[para_waddr]  <= para_zeta;
    end
  end

  // Group counter follows the tag of the accepted beat.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      grp <= '0;
    end else if (accept) begin
      grp <= (tag == GW'(GROUPS - 1)) ? '0 : tag + GW'(1);
    end
  end

  // Table read and d = x - g; gamma/zeta forced to zero outside RPReLU mode.
  always_comb begin
    idx_c   = '0;
    beta_c  = '0;
    gamma_c = '0;
    zeta_c  = '0;
    d_c     = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      idx_c[l]  = AW'(int'(tag) * int'(LANES) + l);
      beta_c[l] = beta_tab[idx_c[l]];
      if (in_mode == MODE_RPRELU) begin
        gamma_c[l] = gamma_tab[idx_c[l]];
        zeta_c[l]  = zeta_tab[idx_c[l]];
      end
      d_c[l] = {data_in[l][DATA_WIDTH-1], data_in[l]}
             - {{(DW1 - PARA_WIDTH){gamma_c[l][PARA_WIDTH-1]}}, gamma_c[l]};
    end
  end

  // Stage 1 register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_mode  <= '0;
      s1_grp   <= '0;
      s1_d     <= '0;
      s1_beta  <= '0;
      s1_zeta  <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_mode  <= in_mode;
      s1_grp   <= tag;
      s1_d     <= d_c;
      s1_beta  <= beta_c;
      s1_zeta  <= zeta_c;
    end
  end

  // Activation and saturation; for ReLU/bypass s1_d already equals x.
  always_comb begin
    pos_c  = '0;
    prod_c = '0;
    y_c    = '0;
    sum_c  = '0;
    res_c  = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      pos_c[l]  = !s1_d[l][DW1-1] && (s1_d[l] != '0);
      prod_c[l] = $signed(MW'($signed(s1_d[l]))) * $signed(MW'($signed(s1_beta[l])));
      y_c[l]    = pos_c[l] ? SW'($signed(s1_d[l]))
                           : SW'($signed(prod_c[l]) >>> BETA_FRAC);
      case (s1_mode)
        MODE_RPRELU, MODE_PRELU: sum_c[l] = y_c[l] + SW'($signed(s1_zeta[l]));
        MODE_RELU:               sum_c[l] = pos_c[l] ? SW'($signed(s1_d[l])) : '0;
        default:                 sum_c[l] = SW'($signed(s1_d[l]));
      endcase
      // In range iff all bits above the result sign bit match it.
      if ((&sum_c[l][SW-1:DATA_WIDTH-1]) || !(|sum_c[l][SW-1:DATA_WIDTH-1])) begin
        res_c[l] = sum_c[l][DATA_WIDTH-1:0];
      end else if (sum_c[l][SW-1]) begin
        res_c[l] = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
      end else begin
        res_c[l] = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
      end
    end
  end

  // Stage 2 register drives the outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_grp   <= '0;
      out_last  <= 1'b0;
      data_out  <= '0;
    end else if (adv) begin
      out_valid <= s1_valid;
      out_grp   <= s1_grp;
      out_last  <= (s1_grp == GW'(GROUPS - 1));
      data_out  <= res_c;
    end
  end

endmodule

// File: tb/tb_rprelu_stream.sv
// Scoreboard bench for rprelu_stream: a driver pushes the reference-model result
// of every accepted beat into a queue; a negedge monitor pops and compares
// whenever an output beat is transferred.
module tb_rprelu_stream;

  localparam int unsigned DW   = 16;
  localparam int unsigned PW   = 16;
  localparam int unsigned BF   = 8;
  localparam int unsigned CH   = 128;
  localparam int unsigned LN   = 16;
  localparam int unsigned GRPS = CH / LN;
  localparam int unsigned AW   = $clog2(CH);
  localparam int unsigned GW   = (GRPS > 1) ? $clog2(GRPS) : 1;
  localparam int unsigned VW   = LN * DW;

  typedef logic [LN-1:0][DW-1:0] vec_t;
  typedef struct {
    logic [GW-1:0] grp;
    logic          last;
    vec_t          data;
    int            acc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic          in_valid, in_ready, in_sof;
  logic [1:0]    in_mode;
  vec_t          data_in;
  logic          para_we;
  logic [AW-1:0] para_waddr;
  logic [PW-1:0] para_beta, para_gamma, para_zeta;
  logic          out_valid, out_ready, out_last;
  logic [GW-1:0] out_grp;
  vec_t          data_out;

  rprelu_stream #(
    .DATA_WIDTH(DW), .PARA_WIDTH(PW), .BETA_FRAC(BF), .CHANNEL_NUM(CH), .LANES(LN)
  ) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_mode(in_mode),
    .data_in(data_in),
    .para_we(para_we), .para_waddr(para_waddr),
    .para_beta(para_beta), .para_gamma(para_gamma), .para_zeta(para_zeta),
    .out_valid(out_valid), .out_ready(out_ready), .out_grp(out_grp),
    .out_last(out_last), .data_out(data_out)
  );

  always #5 clk = ~clk;

  // Reference state: parameter table, group counter, expected-beat queue.
  int   m_beta [CH];
  int   m_gamma[CH];
  int   m_zeta [CH];
  int   m_grp = 0;
  exp_t sbq[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit lat_chk = 1'b0;
  bit accepted;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Activation rule in plain integer arithmetic; floor division for the shift.
  function automatic longint ref_lane(input longint x, input longint b, input longint g,
                                      input longint z, input logic [1:0] mode);
    longint d, p, y, r, scale, hi, lo;
    scale = longint'(1) << BF;
    hi    = (longint'(1) << (DW - 1)) - 1;
    lo    = -(longint'(1) << (DW - 1));
    case (mode)
      2'b00, 2'b01: begin
        if (mode == 2'b01) begin
          g = 0;
          z = 0;
        end
        d = x - g;
        if (d > 0) y = d;
        else begin
          p = d * b;
          y = p / scale;
          if ((p % scale != 0) && (p < 0)) y = y - 1;
        end
        r = y + z;
      end
      2'b10:   r = (x > 0) ? x : 0;
      default: r = x;
    endcase
    if (r > hi) r = hi;
    if (r < lo) r = lo;
    return r;
  endfunction

  task automatic push_expected();
    exp_t   e;
    int     tg, c;
    longint r;
    tg = in_sof ? 0 : m_grp;
    for (int l = 0; l < int'(LN); l++) begin
      c = tg * int'(LN) + l;
      r = ref_lane(longint'($signed(data_in[l])), m_beta[c], m_gamma[c], m_zeta[c], in_mode);
      e.data[l] = DW'(r);
    end
    e.grp  = GW'(tg);
    e.last = (tg == int'(GRPS) - 1);
    e.acc  = cyc;
    sbq.push_back(e);
    m_grp = (tg + 1) % int'(GRPS);
  endtask

  // One clock: decide acceptance at negedge, update the model, return #1 after posedge.
  task automatic tick();
    @(negedge clk);
    accepted = 1'b0;
    if (!rstn) begin
      for (int c = 0; c < int'(CH); c++) begin
        m_beta[c]  = 0;
        m_gamma[c] = 0;
        m_zeta[c]  = 0;
      end
      m_grp = 0;
      sbq.delete();
    end else begin
      if (in_valid && in_ready) begin
        push_expected();
        accepted = 1'b1;
      end
      if (para_we) begin
        m_beta[para_waddr]  = int'($signed(para_beta));
        m_gamma[para_waddr] = int'($signed(para_gamma));
        m_zeta[para_waddr]  = int'($signed(para_zeta));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic write_para(input int c, input int b, input int g, input int z);
    idle();
    para_we    = 1'b1;
    para_waddr = AW'(c);
    para_beta  = PW'(b);
    para_gamma = PW'(g);
    para_zeta  = PW'(z);
    tick();
    para_we = 1'b0;
  endtask

  task automatic send_beat(input bit sof, input logic [1:0] mode, input vec_t d, input bit bp);
    in_valid = 1'b1;
    in_sof   = sof;
    in_mode  = mode;
    data_in  = d;
    for (int t = 0; t < 1000; t++) begin
      if (bp) begin
        out_ready  = 1'($urandom_range(0, 1));
        para_we    = ($urandom_range(0, 3) == 0);
        para_waddr = AW'($urandom);
        para_beta  = PW'(int'($urandom_range(0, 1023)) - 512);
        para_gamma = PW'($urandom);
        para_zeta  = PW'(int'($urandom_range(0, 4095)) - 2048);
      end
      tick();
      if (accepted) return;
    end
    chk("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    idle();
    para_we   = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 100 && sbq.size() != 0; t++) tick();
    if (sbq.size() != 0) chk("drain_timeout", VW'(sbq.size()), 0);
    tick();
    tick();
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    for (int l = 0; l < int'(LN); l++) begin
      case ($urandom_range(0, 7))
        0:       v[l] = {1'b1, {(DW - 1){1'b0}}};
        1:       v[l] = {1'b0, {(DW - 1){1'b1}}};
        2:       v[l] = '0;
        default: v[l] = DW'($urandom);
      endcase
    end
    return v;
  endfunction

  // Monitor: handshake rule, stall stability, and scoreboard pop on transfer.
  exp_t          mon_e;
  vec_t          hold_data;
  logic [GW-1:0] hold_grp;
  bit            stalled = 1'b0;

  always @(negedge clk) begin
    if (!rstn) begin
      stalled <= 1'b0;
    end else begin
      chk("in_ready", in_ready, !out_valid || out_ready);
      if (stalled) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", data_out, hold_data);
        chk("stall_grp", out_grp, hold_grp);
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          mon_e = sbq.pop_front();
          chk("data_out", data_out, mon_e.data);
          chk("out_grp", out_grp, mon_e.grp);
          chk("out_last", out_last, mon_e.last);
          if (lat_chk) chk("latency", VW'(cyc), VW'(mon_e.acc + 2));
        end
      end
      stalled   <= out_valid && !out_ready;
      hold_data <= data_out;
      hold_grp  <= out_grp;
    end
  end

  vec_t v;

  initial begin
    rstn = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_mode = 2'b00; data_in = '0;
    para_we = 1'b0; para_waddr = '0; para_beta = '0; para_gamma = '0; para_zeta = '0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_out_grp", out_grp, 0);
    chk("rst_out_last", out_last, 0);
    rstn    = 1'b1;
    lat_chk = 1'b1;

    // Basic RPReLU on channel 0, positive and negative branch.
    write_para(0, 64, 20, 5);
    v = '0; v[0] = DW'(100);
    send_beat(1'b1, 2'b00, v, 1'b0);
    v[0] = DW'(-100);
    send_beat(1'b1, 2'b00, v, 1'b0);
    drain();

    // Saturation at both rails.
    write_para(1, 0, -32768, 0);
    write_para(2, 256, 32767, 0);
    v = '0; v[1] = DW'(32767); v[2] = DW'(-32768);
    send_beat(1'b1, 2'b00, v, 1'b0);
    drain();

    // All four modes on the same input.
    write_para(3, 128, 7, 3);
    v = '0; v[3] = DW'(-40); v[4] = DW'(25);
    for (int m = 0; m < 4; m++) send_beat(1'b1, 2'(m), v, 1'b0);
    drain();

    // Group sequencing with a random table; in_sof on beats 0 and 8.
    for (int c = 0; c < int'(CH); c++)
      write_para(c, int'($urandom_range(0, 1023)) - 512,
                 int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 4095)) - 2048);
    for (int i = 0; i < 11; i++) send_beat(i == 0 || i == 8, 2'b00, rand_vec(), 1'b0);
    drain();

    // Same-cycle write to channel 0 is not seen by the beat accepted with it.
    write_para(0, 64, 20, 5);
    v = rand_vec(); v[0] = DW'(-300);
    para_we = 1'b1; para_waddr = '0; para_beta = PW'(64); para_gamma = PW'(20); para_zeta = PW'(9);
    send_beat(1'b1, 2'b00, v, 1'b0);
    para_we = 1'b0;
    send_beat(1'b1, 2'b00, v, 1'b0);
    drain();

    // Random backpressure, modes, in_sof and parameter writes.
    lat_chk = 1'b0;
    for (int i = 0; i < 64; i++)
      send_beat($urandom_range(0, 9) == 0, 2'($urandom_range(0, 3)), rand_vec(), 1'b1);
    drain();
    lat_chk = 1'b1;

    // Reset with two beats in flight; a write during reset is dropped.
    send_beat(1'b0, 2'b00, rand_vec(), 1'b0);
    send_beat(1'b0, 2'b00, rand_vec(), 1'b0);
    idle();
    rstn = 1'b0;
    para_we = 1'b1; para_waddr = '0; para_beta = PW'(64); para_gamma = PW'(20); para_zeta = PW'(77);
    tick();
    para_we = 1'b0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_data_out", data_out, 0);
    chk("midrst_out_grp", out_grp, 0);
    chk("midrst_out_last", out_last, 0);
    // Write during reset release is kept.
    rstn = 1'b1;
    para_we = 1'b1; para_waddr = AW'(5); para_beta = '0; para_gamma = '0; para_zeta = PW'(33);
    tick();
    para_we = 1'b0;
    v = rand_vec(); v[0] = DW'(100); v[1] = DW'(-100); v[5] = '0;
    send_beat(1'b0, 2'b00, v, 1'b0);
    send_beat(1'b0, 2'b00, rand_vec(), 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
